// File: rtl/frac_div_sched.sv
// Fractional clock-enable divider: each output period is int or int+1 input cycles, chosen by a first-order accumulator.
// Define FRAC_DIV_STAT_EN to add the period_cnt statistics output.
module frac_div_sched #(
  parameter int unsigned IW = 4,
  parameter int unsigned FW = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          en,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [IW-1:0] cfg_int,
  input  logic [FW-1:0] cfg_num,
  input  logic [FW-1:0] cfg_den,
  output logic          cfg_err,
  output logic          clk_out,
  output logic          tick,
  output logic          busy
`ifdef FRAC_DIV_STAT_EN
  ,
  output logic [15:0]   period_cnt
`endif
);

  localparam int unsigned PW = IW + 1;
  localparam int unsigned SW = FW + 1;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   per_q, per_d;
  logic [FW-1:0]   acc_q, acc_d;
  logic [IW-1:0]   act_int_q, act_int_d;
  logic [FW-1:0]   act_num_q, act_num_d;
  logic [FW-1:0]   act_den_q, act_den_d;
  logic            act_valid_q, act_valid_d;
  logic [IW-1:0]   pend_int_q, pend_int_d;
  logic [FW-1:0]   pend_num_q, pend_num_d;
  logic [FW-1:0]   pend_den_q, pend_den_d;
  logic            pend_valid_q, pend_valid_d;
  logic            clk_d, tick_d, err_d;

  logic            hs, legal, last;
  logic [PW-1:0]   cnt_inc;
  logic            new_period, fresh, src_pend;
  logic [IW-1:0]   sel_int;
  logic [FW-1:0]   sel_num, sel_den, base;
  logic [SW-1:0]   sum;
  logic            ge;
  logic [PW-1:0]   p_new;
  logic [FW-1:0]   acc_new;

  assign hs      = cfg_valid && cfg_ready;
  assign legal   = (cfg_int >= IW'(2)) && (cfg_den != '0) && (cfg_num < cfg_den);
  assign last    = (cnt_q == per_q - PW'(1));
  assign cnt_inc = cnt_q + PW'(1);

  // Next-state, config bookkeeping and next registered output values
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    per_d        = per_q;
    acc_d        = acc_q;
    act_int_d    = act_int_q;
    act_num_d    = act_num_q;
    act_den_d    = act_den_q;
    act_valid_d  = act_valid_q;
    pend_int_d   = pend_int_q;
    pend_num_d   = pend_num_q;
    pend_den_d   = pend_den_q;
    pend_valid_d = pend_valid_q;
    clk_d        = 1'b0;
    tick_d       = 1'b0;
    err_d        = hs && !legal;
    new_period   = 1'b0;
    fresh        = 1'b0;
    src_pend     = 1'b0;
    sel_int      = '0;
    sel_num      = '0;
    sel_den      = '0;
    base         = '0;
    sum          = '0;
    ge           = 1'b0;
    p_new        = '0;
    acc_new      = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A config load takes the cycle; the start waits one cycle so it sees the new config
        if (pend_valid_q) begin
          act_int_d    = pend_int_q;
          act_num_d    = pend_num_q;
          act_den_d    = pend_den_q;
          act_valid_d  = 1'b1;
          pend_valid_d = 1'b0;
        end else if (hs && legal) begin
          act_int_d   = cfg_int;
          act_num_d   = cfg_num;
          act_den_d   = cfg_den;
          act_valid_d = 1'b1;
        end else if (en && act_valid_q) begin
          state_d    = RUN;
          new_period = 1'b1;
          fresh      = 1'b1;
        end
      end
      RUN, STOPPING: begin
        if (hs && legal) begin
          pend_int_d   = cfg_int;
          pend_num_d   = cfg_num;
          pend_den_d   = cfg_den;
          pend_valid_d = 1'b1;
        end
        if (last) begin
          if (pend_valid_q) begin
            act_int_d    = pend_int_q;
            act_num_d    = pend_num_q;
            act_den_d    = pend_den_q;
            pend_valid_d = 1'b0;
            fresh        = 1'b1;
            src_pend     = 1'b1;
          end
          if (en) begin
            state_d    = RUN;
            new_period = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
          end
        end else begin
          state_d = en ? RUN : STOPPING;
          cnt_d   = cnt_inc;
          tick_d  = (cnt_inc == per_q - PW'(1));
          clk_d   = (cnt_inc < (per_q >> 1));
        end
      end
      default: state_d = IDLE;
    endcase

    // Period select from the config in force for the coming period
    sel_int = src_pend ? pend_int_q : act_int_q;
    sel_num = src_pend ? pend_num_q : act_num_q;
    sel_den = src_pend ? pend_den_q : act_den_q;
    base    = fresh ? '0 : acc_q;
    sum     = SW'(base) + SW'(sel_num);
    ge      = (sum >= SW'(sel_den));
    p_new   = ge ? (PW'(sel_int) + PW'(1)) : PW'(sel_int);
    acc_new = ge ? FW'(sum - SW'(sel_den)) : FW'(sum);

    if (new_period) begin
      cnt_d = '0;
      per_d = p_new;
      acc_d = acc_new;
      clk_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      per_q        <= '0;
      acc_q        <= '0;
      act_int_q    <= '0;
      act_num_q    <= '0;
      act_den_q    <= '0;
      act_valid_q  <= 1'b0;
      pend_int_q   <= '0;
      pend_num_q   <= '0;
      pend_den_q   <= '0;
      pend_valid_q <= 1'b0;
      cfg_ready    <= 1'b1;
      cfg_err      <= 1'b0;
      clk_out      <= 1'b0;
      tick         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      per_q        <= per_d;
      acc_q        <= acc_d;
      act_int_q    <= act_int_d;
      act_num_q    <= act_num_d;
      act_den_q    <= act_den_d;
      act_valid_q  <= act_valid_d;
      pend_int_q   <= pend_int_d;
      pend_num_q   <= pend_num_d;
      pend_den_q   <= pend_den_d;
      pend_valid_q <= pend_valid_d;
      cfg_ready    <= !pend_valid_d;
      cfg_err      <= err_d;
      clk_out      <= clk_d;
      tick         <= tick_d;
      busy         <= (state_d != IDLE);
    end
  end

`ifdef FRAC_DIV_STAT_EN
  logic apply_pend;

  assign apply_pend = pend_valid_q && ((state_q == IDLE) || last);

  // Tick counter since the last pending-config application
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      period_cnt <= '0;
    end else if (apply_pend) begin
      period_cnt <= '0;
    end else if (tick) begin
      period_cnt <= period_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frac_div_sched.sv
// Scoreboard bench for frac_div_sched: a cycle reference model queues expected outputs, a monitor compares them.
module tb_frac_div_sched;

  localparam int unsigned IW = 4;
  localparam int unsigned FW = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          en;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [IW-1:0] cfg_int;
  logic [FW-1:0] cfg_num;
  logic [FW-1:0] cfg_den;
  logic          cfg_err;
  logic          clk_out;
  logic          tick;
  logic          busy;
`ifdef FRAC_DIV_STAT_EN
  logic [15:0]   period_cnt;
`endif

  frac_div_sched #(.IW(IW), .FW(FW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_int   (cfg_int),
    .cfg_num   (cfg_num),
    .cfg_den   (cfg_den),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy)
`ifdef FRAC_DIV_STAT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic ready;
    logic err;
    logic clk;
    logic tick;
    logic busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a period is a countdown of P cycles; P from integer accumulator arithmetic
  int m_run, m_pos, m_p, m_acc, m_err;
  int a_i, a_n, a_d, a_v;
  int p_i, p_n, p_d, p_v;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_pick(input int ci, input int cn, input int cd, input int acc_in);
    int s;
    s = acc_in + cn;
    if (s >= cd) begin
      m_p   = ci + 1;
      m_acc = s - cd;
    end else begin
      m_p   = ci;
      m_acc = s;
    end
    m_pos = 0;
  endtask

  task automatic model_step(input bit rst, input bit e, input bit cv, input int ci, input int cn, input int cd);
    bit hs, ok, old_pv, at_end;
    if (rst) begin
      m_run = 0; m_pos = 0; m_p = 0; m_acc = 0; m_err = 0;
      a_v = 0; p_v = 0;
      return;
    end
    hs     = cv && (p_v == 0);
    ok     = (ci >= 2) && (cd != 0) && (cn < cd);
    m_err  = (hs && !ok) ? 1 : 0;
    old_pv = (p_v != 0);
    if (m_run != 0) begin
      at_end = (m_pos == m_p - 1);
      if (at_end) begin
        int base;
        base = m_acc;
        if (old_pv) begin
          a_i = p_i; a_n = p_n; a_d = p_d; p_v = 0; base = 0;
        end
        if (e) model_pick(a_i, a_n, a_d, base);
        else begin
          m_run = 0; m_pos = 0;
        end
      end else begin
        m_pos++;
      end
      if (hs && ok) begin
        p_i = ci; p_n = cn; p_d = cd; p_v = 1;
      end
    end else begin
      if (old_pv) begin
        a_i = p_i; a_n = p_n; a_d = p_d; a_v = 1; p_v = 0;
      end else if (hs && ok) begin
        a_i = ci; a_n = cn; a_d = cd; a_v = 1;
      end else if (e && a_v != 0) begin
        m_run = 1;
        model_pick(a_i, a_n, a_d, 0);
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t o;
    o.ready = (p_v == 0);
    o.err   = (m_err != 0);
    o.busy  = (m_run != 0);
    o.tick  = (m_run != 0) && (m_pos == m_p - 1);
    o.clk   = (m_run != 0) && (m_pos < m_p / 2);
    return o;
  endfunction

  task automatic cycle(input bit rst, input bit e, input bit cv, input int ci, input int cn, input int cd);
    sys_rst   = rst;
    en        = e;
    cfg_valid = cv;
    cfg_int   = IW'(ci);
    cfg_num   = FW'(cn);
    cfg_den   = FW'(cd);
    model_step(rst, e, cv, ci, cn, cd);
    @(posedge sys_clk);
    #1;
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) cycle(1'b0, e, 1'b0, 0, 0, 0);
  endtask

  task automatic rand_cfg(output int ci, output int cn, output int cd);
    int k;
    k  = int'($urandom_range(0, 9));
    ci = int'($urandom_range(2, 15));
    cd = int'($urandom_range(1, 12));
    if ($urandom_range(0, 3) == 0) cd = int'($urandom_range(1, 255));
    cn = int'($urandom_range(0, cd - 1));
    case (k)
      0: ci = int'($urandom_range(0, 1));
      1: cd = 0;
      2: cn = int'($urandom_range(cd, 255));
      default: ;
    endcase
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  always @(negedge sys_clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("cfg_ready", int'(cfg_ready), int'(x.ready));
      chk("cfg_err",   int'(cfg_err),   int'(x.err));
      chk("clk_out",   int'(clk_out),   int'(x.clk));
      chk("tick",      int'(tick),      int'(x.tick));
      chk("busy",      int'(busy),      int'(x.busy));
    end
  end

  // Period-length recorder for the directed 8.7 pattern
  bit rec_on = 1'b0;
  int run_len = 0;
  int per_q[$];

  always @(negedge sys_clk) begin
    if (rec_on && busy === 1'b1) begin
      run_len++;
      if (tick === 1'b1) begin
        per_q.push_back(run_len);
        run_len = 0;
      end
    end
  end

  initial begin
    int exp_tab[10];
    int sum;
    int ci, cn, cd;
    bit r_en;
    exp_tab = '{8, 9, 9, 8, 9, 9, 8, 9, 9, 9};

    sys_rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    cfg_int = '0; cfg_num = '0; cfg_den = '0;

    repeat (3) cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);

    // 8 + 7/10
    cycle(1'b0, 1'b0, 1'b1, 8, 7, 10);
    rec_on = 1'b1;
    run(100, 1'b1);
    rec_on = 1'b0;
    sum = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < per_q.size()) begin
        chk("period_len", per_q[i], exp_tab[i]);
        sum += per_q[i];
      end else begin
        chk("period_missing", i, per_q.size());
      end
    end
    chk("ten_period_sum", sum, 87);

    // Mid-period change to 5/0/1
    run(3, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 5, 0, 1);
    run(30, 1'b1);

    // Illegal config while running
    cycle(1'b0, 1'b1, 1'b1, 2, 1, 0);
    run(12, 1'b1);

    // Pending 8/7/10, then stop and restart
    cycle(1'b0, 1'b1, 1'b1, 8, 7, 10);
    run(20, 1'b1);
    run(25, 1'b0);
    run(40, 1'b1);

    // Integer divide by 4
    run(20, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 4, 0, 1);
    run(24, 1'b1);

    // Alternating 2,3
    cycle(1'b0, 1'b1, 1'b1, 2, 1, 2);
    run(20, 1'b1);

    // Reset mid-period
    run(2, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 0, 0, 0);
    run(5, 1'b1);

    // Randomized traffic
    r_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit rst, cv;
      if ($urandom_range(0, 39) == 0) r_en = !r_en;
      rst = ($urandom_range(0, 599) == 0);
      cv  = ($urandom_range(0, 9) == 0);
      rand_cfg(ci, cn, cd);
      cycle(rst, r_en, cv, ci, cn, cd);
    end

    @(negedge sys_clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
